// File: rtl/if_fetch_buffer.sv
// Instruction-fetch stage: owns the fetch PC, issues word requests over a
// req/gnt + rvalid memory interface, pairs each response with its PC and
// buffers {instruction, PC} in an in-order FIFO presented to decode.
// Redirects flush the FIFO and mark in-flight responses as stale so they are
// discarded on arrival.
// Optional build macro: FETCH_PERF_CNT_EN adds perf_stall_o / perf_flush_o.
module if_fetch_buffer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  input  logic        inst_ready_i
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_o,
  output logic [31:0] perf_flush_o
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_W = (CNT_W+1)'(DEPTH);

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [PTR_W-1:0] ptr_t;

  // Control state
  logic [31:0] fetch_pc;
  cnt_t        live_cnt;
  cnt_t        stale_cnt;
  cnt_t        occ;
  ptr_t        pcq_wr, pcq_rd;
  ptr_t        fifo_wr, fifo_rd;

  // Data storage (not reset; qualified by the control counters)
  logic [31:0] pcq_mem  [DEPTH];
  logic [31:0] inst_mem [DEPTH];
  logic [31:0] ipc_mem  [DEPTH];

  logic           pop;
  logic [CNT_W:0] fill_sum;
  logic [CNT_W:0] outstanding_sum;
  logic           rsp_any;
  logic           rsp_drop;
  logic           rsp_keep;
  logic           fire;

  // Pop-aware fill check keeps one instruction per cycle flowing with DEPTH=2:
  // a slot freed by decode this cycle may already be claimed by a new request.
  assign pop             = (occ != '0) && inst_ready_i;
  assign fill_sum        = {1'b0, occ} + {1'b0, live_cnt} - (CNT_W+1)'(pop);
  assign outstanding_sum = {1'b0, live_cnt} + {1'b0, stale_cnt};

  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp_any  = imem_rvalid_i && ((live_cnt != '0) || (stale_cnt != '0));
  assign rsp_drop = rsp_any && ((stale_cnt != '0) || redirect_i);
  assign rsp_keep = rsp_any && !rsp_drop;

  assign imem_req_o  = !rst_i && !redirect_i &&
                       (fill_sum < DEPTH_W) && (outstanding_sum < DEPTH_W);
  assign imem_addr_o = fetch_pc;
  assign fire        = imem_req_o && imem_gnt_i;

  // Outputs are gated by valid so an empty or freshly reset FIFO shows zeros.
  assign inst_valid_o = (occ != '0);
  assign inst_o       = inst_valid_o ? inst_mem[fifo_rd] : 32'h0;
  assign inst_pc_o    = inst_valid_o ? ipc_mem[fifo_rd]  : 32'h0;

  // PC, outstanding-request counters and FIFO/PC-queue pointers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_pc  <= RESET_PC;
      live_cnt  <= '0;
      stale_cnt <= '0;
      occ       <= '0;
      pcq_wr    <= '0;
      pcq_rd    <= '0;
      fifo_wr   <= '0;
      fifo_rd   <= '0;
    end else if (redirect_i) begin
      // Everything in flight becomes stale; a response arriving now is the
      // oldest outstanding one and is dropped immediately.
      fetch_pc  <= redirect_pc_i & 32'hFFFF_FFFC;
      stale_cnt <= stale_cnt + live_cnt - cnt_t'(rsp_any);
      live_cnt  <= '0;
      occ       <= '0;
      pcq_wr    <= '0;
      pcq_rd    <= '0;
      fifo_wr   <= '0;
      fifo_rd   <= '0;
    end else begin
      if (fire) fetch_pc <= fetch_pc + 32'd4;
      stale_cnt <= stale_cnt - cnt_t'(rsp_drop);
      live_cnt  <= live_cnt + cnt_t'(fire) - cnt_t'(rsp_keep);
      occ       <= occ + cnt_t'(rsp_keep) - cnt_t'(pop);
      pcq_wr    <= pcq_wr + ptr_t'(fire);
      pcq_rd    <= pcq_rd + ptr_t'(rsp_keep);
      fifo_wr   <= fifo_wr + ptr_t'(rsp_keep);
      fifo_rd   <= fifo_rd + ptr_t'(pop);
    end
  end

  // Record the PC of each granted request; pair live responses with it
  always_ff @(posedge clk_i) begin
    if (fire) pcq_mem[pcq_wr] <= fetch_pc;
    if (rsp_keep) begin
      inst_mem[fifo_wr] <= imem_rdata_i;
      ipc_mem[fifo_wr]  <= pcq_mem[pcq_rd];
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Decode-stall cycles and instructions discarded by redirects
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_stall_o <= 32'h0;
      perf_flush_o <= 32'h0;
    end else begin
      if (inst_valid_o && !inst_ready_i) perf_stall_o <= perf_stall_o + 32'd1;
      if (redirect_i)
        perf_flush_o <= perf_flush_o + 32'(occ) - 32'(pop) + 32'(rsp_any);
      else
        perf_flush_o <= perf_flush_o + 32'(rsp_drop);
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_buffer.sv
// Directed bench for if_fetch_buffer: a fixed-latency in-order memory model
// returns ~addr for each granted address; a second instance checks PC wrap.
module tb_if_fetch_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        ready;

  logic        req,   req2;
  logic [31:0] addr,  addr2;
  logic        valid, valid2;
  logic [31:0] inst,  inst2;
  logic [31:0] pc,    pc2;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_stall, perf_flush, perf_stall2, perf_flush2;
`endif

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;
  int lat  = 1;
  logic [31:0] q_addr[$];
  int          q_due[$];

  always #5 clk = ~clk;

  if_fetch_buffer #(.RESET_PC(32'h0000_0000), .DEPTH(2)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .imem_req_o(req), .imem_addr_o(addr), .imem_gnt_i(gnt),
    .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .inst_valid_o(valid), .inst_o(inst), .inst_pc_o(pc),
    .inst_ready_i(ready)
`ifdef FETCH_PERF_CNT_EN
    , .perf_stall_o(perf_stall), .perf_flush_o(perf_flush)
`endif
  );

  if_fetch_buffer #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) u_wrap (
    .clk_i(clk), .rst_i(rst),
    .imem_req_o(req2), .imem_addr_o(addr2), .imem_gnt_i(gnt),
    .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .inst_valid_o(valid2), .inst_o(inst2), .inst_pc_o(pc2),
    .inst_ready_i(ready)
`ifdef FETCH_PERF_CNT_EN
    , .perf_stall_o(perf_stall2), .perf_flush_o(perf_flush2)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: record any grant, advance, then present due responses.
  task automatic tick();
    logic        f;
    logic [31:0] a;
    f = req && gnt;
    a = addr;
    @(posedge clk);
    #1;
    cyc++;
    if (f) begin
      q_addr.push_back(a);
      q_due.push_back(cyc - 1 + lat);
    end
    rvalid = 1'b0;
    rdata  = 32'h0;
    if (q_due.size() > 0 && q_due[0] <= cyc) begin
      rvalid = 1'b1;
      rdata  = ~q_addr[0];
      void'(q_addr.pop_front());
      void'(q_due.pop_front());
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    q_addr.delete();
    q_due.delete();
    rvalid = 1'b0;
    rdata = 32'h0;
    redirect = 1'b0;
    #1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    int n;
    rst = 1'b1; gnt = 1'b1; rvalid = 1'b0; rdata = 32'h0;
    redirect = 1'b0; redirect_pc = 32'h0; ready = 1'b1;

    // Reset state
    tick();
    tick();
    chk("rst_req",   {31'h0, req},   32'h0);
    chk("rst_valid", {31'h0, valid}, 32'h0);
    chk("rst_inst",  inst, 32'h0);
    chk("rst_pc",    pc,   32'h0);

    // Streaming, 1-cycle memory, decode always ready; wrap instance alongside
    lat = 1;
    rst = 1'b0;
    #1;
    chk("c0_req",   {31'h0, req}, 32'h1);
    chk("c0_addr",  addr,  32'h0);
    chk("c0_addr2", addr2, 32'hFFFF_FFF8);
    tick();
    chk("c1_valid", {31'h0, valid}, 32'h0);
    chk("c1_addr",  addr, 32'h4);
    tick();
    for (int k = 0; k < 6; k++) begin
      chk("stream_valid", {31'h0, valid}, 32'h1);
      chk("stream_pc",    pc,   32'(4 * k));
      chk("stream_inst",  inst, ~32'(4 * k));
      chk("wrap_valid",   {31'h0, valid2}, 32'h1);
      chk("wrap_pc",      pc2,  32'hFFFF_FFF8 + 32'(4 * k));
      chk("wrap_inst",    inst2, ~32'(4 * k));
      tick();
    end

    // Decode stall after two fetches
    ready = 1'b0;
    do_reset();
    tick();
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("stall_req", {31'h0, req}, 32'h0);
      tick();
    end
    chk("stall_valid", {31'h0, valid}, 32'h1);
    chk("stall_pc",    pc, 32'h0);
    ready = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("release_valid", {31'h0, valid}, 32'h1);
      chk("release_pc",    pc, 32'(4 * k));
      tick();
    end

    // Redirect with two requests outstanding, 3-cycle memory
    lat = 3;
    do_reset();
    tick();
    tick();
    chk("lat3_req_cap", {31'h0, req}, 32'h0);
    redirect = 1'b1;
    redirect_pc = 32'h0000_0103;
    #1;
    chk("redir_req", {31'h0, req}, 32'h0);
    tick();
    redirect = 1'b0;
    #1;
    n = 0;
    while (!valid && n < 20) begin
      tick();
      n++;
    end
    chk("redir_wait", 32'(n), 32'd5);
    chk("redir_pc",   pc,   32'h0000_0100);
    chk("redir_inst", inst, ~32'h0000_0100);
    tick();
    chk("redir_pc_next", pc, 32'h0000_0104);

    // Redirect coinciding with a response and an accepted pop
    lat = 1;
    do_reset();
    tick();
    tick();
    chk("coinc_rvalid", {31'h0, rvalid}, 32'h1);
    redirect = 1'b1;
    redirect_pc = 32'h0000_0200;
    #1;
    chk("coinc_req",   {31'h0, req},   32'h0);
    chk("coinc_valid", {31'h0, valid}, 32'h1);
    tick();
    redirect = 1'b0;
    #1;
    chk("coinc_empty", {31'h0, valid}, 32'h0);
    chk("coinc_req_n1", {31'h0, req}, 32'h1);
    chk("coinc_addr_n1", addr, 32'h0000_0200);
    tick();
    chk("coinc_valid_n2", {31'h0, valid}, 32'h0);
    tick();
    chk("coinc_valid_n3", {31'h0, valid}, 32'h1);
    chk("coinc_pc_n3",    pc, 32'h0000_0200);

    // Asynchronous reset while the FIFO is full
    ready = 1'b0;
    do_reset();
    tick();
    tick();
    tick();
    chk("full_valid", {31'h0, valid}, 32'h1);
    chk("full_req",   {31'h0, req},   32'h0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", {31'h0, valid}, 32'h0);
    chk("arst_inst",  inst, 32'h0);
    chk("arst_pc",    pc,   32'h0);
    chk("arst_req",   {31'h0, req}, 32'h0);
    q_addr.delete();
    q_due.delete();
    rvalid = 1'b0;
    rdata = 32'h0;
    tick();
    rst = 1'b0;
    ready = 1'b1;
    #1;
`ifdef FETCH_PERF_CNT_EN
    chk("perf_stall_rst", perf_stall, 32'h0);
    chk("perf_flush_rst", perf_flush, 32'h0);
`endif
    chk("restart_req",  {31'h0, req}, 32'h1);
    chk("restart_addr", addr, 32'h0);
    tick();
    tick();
    chk("restart_valid", {31'h0, valid}, 32'h1);
    chk("restart_pc",    pc, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
